// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants and output-register state encoding for the dual-port RAM FIFO controller.
package dpram_fifo_ctrl_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/dpram_fifo_ctrl_fifo_ptr_cnt.sv
// Write/read pointers and RAM occupancy counter; full and empty are judged from level alone.
module fifo_ptr_cnt #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              inc,
  input  logic              dec,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   level
);

  // Pointers wrap naturally at 2**ADDR_W; simultaneous inc and dec leave level unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (inc) wr_ptr <= wr_ptr + 1'b1;
      if (dec) rd_ptr <= rd_ptr + 1'b1;
      if (inc && !dec)
        level <= level + 1'b1;
      else if (dec && !inc)
        level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving a 16x8 true dual-port RAM: port 0 writes on the rising edge,
// port 1 reads on the falling edge, and a one-entry output register hides the read latency.
module dpram_fifo_ctrl
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int AF_LEVEL = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] ram_addr_0,
  output logic [DATA_W-1:0] ram_wdata_0,
  output logic              ram_we_0,
  output logic              ram_re_0,
  output logic [ADDR_W-1:0] ram_addr_1,
  input  logic [DATA_W-1:0] ram_rdata_1,
  output logic              ram_we_1,
  output logic              ram_re_1,
  output logic [ADDR_W:0]   level,
  output logic              almost_full
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(2 ** ADDR_W);
  localparam logic [ADDR_W:0] AF_THRESH  = (ADDR_W+1)'(AF_LEVEL);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr;
  logic              rd;
  out_state_t        state;

  // in_ready depends only on registered level, so no combinational path from out_ready.
  assign in_ready    = (level != FULL_LEVEL);
  assign almost_full = (level >= AF_THRESH);
  assign wr          = in_valid && in_ready && !flush;
  assign rd          = (level != '0) && (!out_valid || out_ready) && !flush;

  assign ram_we_0    = wr;
  assign ram_addr_0  = wr_ptr;
  assign ram_wdata_0 = in_data;
  assign ram_re_0    = 1'b0;
  assign ram_re_1    = rd;
  assign ram_addr_1  = rd_ptr;
  assign ram_we_1    = 1'b0;

  fifo_ptr_cnt #(.ADDR_W(ADDR_W)) u_ptr_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .inc    (wr),
    .dec    (rd),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .level  (level)
  );

  // RAM data captured on the falling edge is loaded here at the rising edge closing the read cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (rd) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= ram_rdata_1;
          end
        end
        FULL: begin
          if (rd) begin
            out_data <= ram_rdata_1;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural 16x8 dual-port RAM attached.
module tb_dpram_fifo_ctrl;
  import dpram_fifo_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] ram_addr_0;
  logic [7:0] ram_wdata_0;
  logic       ram_we_0;
  logic       ram_re_0;
  logic [3:0] ram_addr_1;
  logic [7:0] ram_rdata_1;
  logic       ram_we_1;
  logic       ram_re_1;
  logic [4:0] level;
  logic       almost_full;

  int n_cmp;
  int n_fail;

  logic [7:0] mem [DEPTH];

  dpram_fifo_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .ram_addr_0  (ram_addr_0),
    .ram_wdata_0 (ram_wdata_0),
    .ram_we_0    (ram_we_0),
    .ram_re_0    (ram_re_0),
    .ram_addr_1  (ram_addr_1),
    .ram_rdata_1 (ram_rdata_1),
    .ram_we_1    (ram_we_1),
    .ram_re_1    (ram_re_1),
    .level       (level),
    .almost_full (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port 0 writes on the rising edge, port 1 reads on the falling edge.
  always @(posedge clk) if (ram_we_0) mem[ram_addr_0] <= ram_wdata_0;
  always @(negedge clk) if (ram_re_1) ram_rdata_1 <= mem[ram_addr_1];

  typedef struct packed {
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic [4:0] level;
    logic       we0;
    logic       re1;
    logic [3:0] addr0;
    logic [3:0] addr1;
    logic       af;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(logic fl, logic iv, logic [7:0] id, logic ordy,
                              logic ir, logic ov, logic [7:0] od, logic [4:0] lv,
                              logic we, logic re, logic [3:0] a0, logic [3:0] a1, logic af);
    vec_t v;
    v = '{fl, iv, id, ordy, ir, ov, od, lv, we, re, a0, a1, af};
    return v;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(posedge clk);
    #1;
    flush     = v.flush;
    in_valid  = v.in_valid;
    in_data   = v.in_data;
    out_ready = v.out_ready;
  endtask

  task automatic check_output(input int idx, input vec_t v);
    #3;
    check_val($sformatf("v%0d.in_ready", idx),  in_ready,    v.in_ready);
    check_val($sformatf("v%0d.out_valid", idx), out_valid,   v.out_valid);
    check_val($sformatf("v%0d.out_data", idx),  out_data,    v.out_data);
    check_val($sformatf("v%0d.level", idx),     level,       v.level);
    check_val($sformatf("v%0d.we0", idx),       ram_we_0,    v.we0);
    check_val($sformatf("v%0d.re1", idx),       ram_re_1,    v.re1);
    check_val($sformatf("v%0d.addr0", idx),     ram_addr_0,  v.addr0);
    check_val($sformatf("v%0d.addr1", idx),     ram_addr_1,  v.addr1);
    check_val($sformatf("v%0d.af", idx),        almost_full, v.af);
    if (v.we0) check_val($sformatf("v%0d.wdata0", idx), ram_wdata_0, v.in_data);
  endtask

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #3;
  endtask

  initial begin
    logic [7:0] exp_data;
    logic [7:0] sb [$];
    logic [7:0] prev_data;
    logic       prev_stall;
    int         sent;
    int         recvd;
    int         exp_lv;

    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    //           fl iv data   or  ir ov od     lv we re a0 a1 af
    vecs[0]  = mk(0, 1, 8'hA5, 1,  1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 1, 0, 1, 1, 0, 0);
    vecs[2]  = mk(0, 0, 8'h00, 1,  1, 1, 8'hA5, 0, 0, 0, 1, 1, 0);
    vecs[3]  = mk(0, 0, 8'h00, 1,  1, 0, 8'hA5, 0, 0, 0, 1, 1, 0);
    vecs[4]  = mk(0, 1, 8'hB0, 0,  1, 0, 8'hA5, 0, 1, 0, 1, 1, 0);
    vecs[5]  = mk(0, 1, 8'hB1, 0,  1, 0, 8'hA5, 1, 1, 1, 2, 1, 0);
    vecs[6]  = mk(0, 1, 8'hB2, 0,  1, 1, 8'hB0, 1, 1, 0, 3, 2, 0);
    vecs[7]  = mk(0, 1, 8'hB3, 0,  1, 1, 8'hB0, 2, 1, 0, 4, 2, 0);
    vecs[8]  = mk(0, 1, 8'hB4, 0,  1, 1, 8'hB0, 3, 1, 0, 5, 2, 0);
    vecs[9]  = mk(0, 1, 8'hB5, 0,  1, 1, 8'hB0, 4, 1, 0, 6, 2, 0);
    vecs[10] = mk(1, 1, 8'hC9, 1,  1, 1, 8'hB0, 5, 0, 0, 7, 2, 0);
    vecs[11] = mk(0, 1, 8'hC0, 1,  1, 0, 8'h00, 0, 1, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 8'h00, 1,  1, 0, 8'h00, 1, 0, 1, 1, 0, 0);
    vecs[13] = mk(0, 0, 8'h00, 1,  1, 1, 8'hC0, 0, 0, 0, 1, 1, 0);

    #2;
    check_val("rst.out_valid", out_valid, 0);
    check_val("rst.out_data", out_data, 0);
    check_val("rst.level", level, 0);
    check_val("rst.in_ready", in_ready, 1);
    check_val("rst.we0", ram_we_0, 0);
    check_val("rst.re1", ram_re_1, 0);
    check_val("rst.re0", ram_re_0, 0);
    check_val("rst.we1", ram_we_1, 0);
    #8;
    rst_n = 1'b1;

    $display("[TB] table vectors");
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i]);
      check_output(i, vecs[i]);
    end

    $display("[TB] fill to 16 then drain");
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      exp_lv = (i <= 1) ? i : i - 1;
      check_val($sformatf("fill%0d.in_ready", i), in_ready, 1);
      check_val($sformatf("fill%0d.level", i), level, exp_lv);
      check_val($sformatf("fill%0d.af", i), almost_full, (exp_lv >= 14));
    end
    drive(1'b1, 8'h10, 1'b0);
    check_val("fill16.level", level, 15);
    check_val("fill16.in_ready", in_ready, 1);
    drive(1'b1, 8'hEE, 1'b1);
    check_val("full.level", level, 16);
    check_val("full.in_ready", in_ready, 0);
    check_val("full.af", almost_full, 1);
    check_val("full.we0", ram_we_0, 0);
    check_val("full.re1", ram_re_1, 1);
    check_val("full.out_valid", out_valid, 1);
    check_val("full.out_data", out_data, 8'h00);
    exp_data = 8'h01;
    for (int c = 0; c < 100 && exp_data != 8'h11; c++) begin
      drive(1'b0, 8'h00, 1'b1);
      if (c == 0) begin
        check_val("pop.level", level, 15);
        check_val("pop.in_ready", in_ready, 1);
      end
      if (out_valid) begin
        check_val($sformatf("drain%0d.data", exp_data), out_data, exp_data);
        exp_data++;
      end
    end
    check_val("drain.count", exp_data, 8'h11);

    $display("[TB] random stall stream");
    sent = 0; recvd = 0; prev_stall = 1'b0; prev_data = '0;
    for (int c = 0; c < 3000 && recvd < 40; c++) begin
      drive((sent < 40) && ($urandom_range(0, 3) != 0), 8'(sent * 7 + 3),
            ($urandom_range(0, 2) != 0));
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        sent++;
      end
      if (out_valid) begin
        if (prev_stall) check_val("stall.hold", out_data, prev_data);
        if (out_ready) begin
          if (sb.size() == 0) check_val("stream.underflow", 1, 0);
          else check_val($sformatf("stream%0d", recvd), out_data, sb.pop_front());
          recvd++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    check_val("stream.count", recvd, 40);

    $display("[TB] reset mid-operation");
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    check_val("pre.level", level, 2);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mrst.level", level, 0);
    check_val("mrst.out_valid", out_valid, 0);
    check_val("mrst.out_data", out_data, 0);
    check_val("mrst.in_ready", in_ready, 1);
    check_val("mrst.we0", ram_we_0, 0);
    check_val("mrst.re1", ram_re_1, 0);
    check_val("mrst.addr0", ram_addr_0, 0);
    #3;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- FIFO controller that sits directly upstream of the 16x8 true dual-port RAM and drives it.
- Port 0 is the write port (rising edge). Port 1 is the read port (falling edge).
- Presents a valid/ready stream on both sides and hides RAM latency behind a one-entry output register.
- Used wherever a producer/consumer pair needs elastic buffering through the shared dual-port RAM.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 4, RAM address width; depth is 2**ADDR_W = 16.
- AF_LEVEL, 14, RAM occupancy at or above which almost_full asserts.

Ports:
- clk  in  1  single clock; RAM port 0 samples on rising edge, port 1 on falling edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all FIFO state.
- in_data  in  DATA_W  write payload.
- in_valid  in  1  producer has data.
- in_ready  out  1  controller accepts data.
- out_data  out  DATA_W  read payload (registered).
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts data.
- ram_addr_0  out  ADDR_W  RAM port-0 address (= wr_ptr).
- ram_wdata_0  out  DATA_W  RAM port-0 write data (= in_data).
- ram_we_0  out  1  RAM port-0 write enable.
- ram_re_0  out  1  tied 0.
- ram_addr_1  out  ADDR_W  RAM port-1 address (= rd_ptr).
- ram_rdata_1  in  DATA_W  RAM port-1 read data.
- ram_we_1  out  1  tied 0.
- ram_re_1  out  1  RAM port-1 read enable.
- level  out  ADDR_W+1  words held in RAM, 0..16; excludes the output register.
- almost_full  out  1  level >= AF_LEVEL.

Behaviour:
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, level=0, out_valid=0, out_data=0.
  - Consequence: in_ready=1, almost_full=0, ram_we_0=0, ram_re_1=0.
- in_ready = (level != 2**ADDR_W). It is computed from the registered level only; there is no combinational path from out_ready.
- Write (combinational, same cycle): wr = in_valid && in_ready.
  - ram_we_0=wr, ram_addr_0=wr_ptr, ram_wdata_0=in_data.
  - wr_ptr increments at the rising edge.
- Read issue (combinational): rd = (level != 0) && (!out_valid || out_ready).
  - ram_re_1=rd, ram_addr_1=rd_ptr.
  - The RAM captures on the falling edge mid-cycle, so ram_rdata_1 is valid at the rising edge ending that cycle.
  - At that edge: out_data <= ram_rdata_1, out_valid <= 1, rd_ptr increments.
- Output register FSM:
  - EMPTY -> FULL on rd.
  - FULL -> FULL on rd (including out_ready && rd).
  - FULL -> EMPTY on out_ready && !rd.
  - out_data holds while out_valid && !out_ready.
- Latency: a word written in cycle N appears with out_valid=1 in cycle N+2, given an empty FIFO and out_ready=1. There is no write-to-read bypass.
- level update: +1 on wr only, -1 on rd only, unchanged on both or neither.
- Pointer wrap: both pointers wrap 15->0 naturally; full/empty are decided by level, not by pointer compare.
- Boundary conditions:
  - wr and rd in the same cycle with level=0: rd is not issued, level goes 0->1.
  - level=16 and rd in the same cycle: in_ready=0, so no write; level goes 15, in_ready rises next cycle.
  - Same-address hazard is impossible: reads only target occupied entries and writes only target free entries.
- flush (sync, takes priority over wr/rd): same state as reset; ram_we_0 and ram_re_1 are forced 0 in the flush cycle.
- Reset mid-operation: all state clears immediately; RAM contents are don't-care.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, the DEPTH constant, and the output FSM state encoding (EMPTY=0, FULL=1).
- One natural sub-module: fifo_ptr_cnt, holding wr_ptr, rd_ptr and level, with inc/dec inputs and flush.

Test Plan:
- Reset with rst_n=0 mid-cycle -> all outputs 0 immediately, in_ready=1; no RAM enable asserted.
- Write 0xA5 at cycle 0 with out_ready=1 -> ram_we_0=1 with addr 0 at cycle 0; ram_re_1=1 with addr 0 at cycle 1; out_valid=1 with out_data=0xA5 at cycle 2; level returns to 0.
- Write 0x00..0x0F with out_ready=0 -> level goes 15 after the first word is prefetched into the output register; write 0x10 -> level=16, in_ready=0, almost_full=1. Drain all 17 words in order 0x00..0x10.
- Write 40 words with continuous reads and random out_ready stalls -> in-order data; rd_ptr and wr_ptr wrap twice; out_data stable while stalled.
- level=16 with a simultaneous pop -> no write that cycle; in_ready=1 the next cycle.
- flush with level=5 and out_valid=1 -> next cycle level=0, out_valid=0; a subsequent write lands at ram_addr_0=0.
